rcb_frl_training_detect: RTL and testbench
==========================================

RCB_FRL_TRAINING_DETECT -- requirements
Module: rcb_frl_training_detect

Interface
REQ-001 SHALL have parameter MATCH_LEN, default 64: consecutive good bytes needed to declare lock (range 2..255).
REQ-002 SHALL have parameter SLIP_WAIT, default 8: idle cycles after each BIT_SLIP pulse before re-checking (range 1..255).
REQ-003 SHALL have parameter LOSS_LEN, default 4: consecutive bad bytes in lock that drop lock (range 1..15).
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port TRAIN_EN  input  1  high enables training search; low aborts.
REQ-007 SHALL have port DATA_IN  input  8  deserialized receive byte.
REQ-008 SHALL have port DATA_VALID  input  1  DATA_IN qualifier.
REQ-009 SHALL have port BIT_SLIP  output  1  one-cycle pulse to the deserializer bitslip input.
REQ-010 SHALL have port LOCKED  output  1  high while the training pattern is aligned.
REQ-011 SHALL have port ERR_CNT  output  16  bad bytes seen while LOCKED.

Function
REQ-012 SHALL register the last valid byte as PREV; PREV updates only when DATA_VALID=1.
REQ-013 A valid byte SHALL be good iff DATA_IN is 8'hF4 or 8'hC2 and DATA_IN != PREV; otherwise bad.
REQ-014 SHALL implement states SEARCH, SLIP, WAIT, LOCK; all outputs registered.
REQ-015 SEARCH: good byte increments MATCH_CNT; the good byte that makes MATCH_CNT reach MATCH_LEN SHALL move to LOCK, LOCKED high on the next cycle.
REQ-016 SEARCH: bad byte SHALL clear MATCH_CNT and move to SLIP.
REQ-017 SLIP: BIT_SLIP SHALL be high for exactly one cycle, then move to WAIT.
REQ-018 WAIT: SHALL count SLIP_WAIT clock cycles regardless of DATA_VALID, ignore data (PREV still updates), then return to SEARCH with MATCH_CNT=0.
REQ-019 LOCK: bad byte increments MISS_CNT; good byte clears MISS_CNT; MISS_CNT reaching LOSS_LEN SHALL move to SEARCH, LOCKED low the next cycle, MATCH_CNT and MISS_CNT cleared.
REQ-020 DATA_VALID=0 SHALL freeze MATCH_CNT, MISS_CNT and state in SEARCH and LOCK.
REQ-021 TRAIN_EN=0 SHALL force SEARCH next cycle from any state, clear MATCH_CNT/MISS_CNT, deassert LOCKED, suppress BIT_SLIP; TRAIN_EN=0 overrides any simultaneous transition.
REQ-022 BIT_SLIP SHALL never pulse on two consecutive cycles; minimum spacing 1+SLIP_WAIT+1 cycles.

Reset
REQ-023 RST high SHALL asynchronously set state SEARCH, PREV=8'h00, all counters 0, BIT_SLIP=0, LOCKED=0, ERR_CNT=0.
REQ-024 RST asserted mid-LOCK or mid-WAIT SHALL abort immediately with no BIT_SLIP pulse on release; first post-reset byte is compared against PREV=8'h00 (hence bad if not F4/C2, good if F4/C2).

Configuration
REQ-025 Macro RCB_FRL_TRAIN_ERRCNT_EN defined: ERR_CNT increments on each bad valid byte in LOCK, saturates at 16'hFFFF, clears on RST or on TRAIN_EN rising edge.
REQ-026 Macro RCB_FRL_TRAIN_ERRCNT_EN undefined: ERR_CNT port present, tied to 16'h0000, no counter logic.

Verification
REQ-027 Reset, TRAIN_EN=1, continuous valid F4,C2,F4,... -> no BIT_SLIP; LOCKED rises the cycle after the 64th good byte.
REQ-028 Stream 8'h7A,8'h15 (misaligned) -> BIT_SLIP pulse one cycle after first bad byte, next pulse exactly 10 cycles later while stream stays bad; after switching to aligned pattern, LOCKED after 64 good bytes.
REQ-029 In LOCK inject 3 bad bytes then good -> LOCKED stays 1, ERR_CNT=3 (macro on) / 0 (macro off); inject 4 consecutive bad -> LOCKED=0 next cycle.
REQ-030 Repeated byte F4,F4 in SEARCH after 30 good -> MATCH_CNT cleared, BIT_SLIP pulse, lock requires full 64 again.
REQ-031 TRAIN_EN dropped during SLIP and during LOCK -> no BIT_SLIP, LOCKED=0 next cycle, state SEARCH; DATA_VALID gaps of 5 cycles during SEARCH -> lock count unaffected.
REQ-032 RST pulsed mid-LOCK (async, between edges) -> LOCKED and ERR_CNT 0 immediately, no BIT_SLIP after release.

Source files
------------

// File: rtl/rcb_frl_training_detect.sv
// FRL training-pattern detector: aligns the deserializer with BIT_SLIP until F4/C2 locks.
// Optional saturating error counter enabled by RCB_FRL_TRAIN_ERRCNT_EN.
module rcb_frl_training_detect #(
  parameter int MATCH_LEN = 64,
  parameter int SLIP_WAIT = 8,
  parameter int LOSS_LEN  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TRAIN_EN,
  input  logic [7:0]  DATA_IN,
  input  logic        DATA_VALID,
  output logic        BIT_SLIP,
  output logic        LOCKED,
  output logic [15:0] ERR_CNT
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  localparam logic [7:0] MATCH_LAST = 8'(MATCH_LEN - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(SLIP_WAIT - 1);
  localparam logic [3:0] LOSS_LAST  = 4'(LOSS_LEN - 1);

  // A training byte is one of the two pattern symbols and must toggle against the previous one.
  function automatic logic is_good_byte(input logic [7:0] data, input logic [7:0] prev);
    return ((data == 8'hF4) || (data == 8'hC2)) && (data != prev);
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  prev_r;
  logic [7:0]  match_cnt_r, match_cnt_s;
  logic [3:0]  miss_cnt_r, miss_cnt_s;
  logic [7:0]  wait_cnt_r, wait_cnt_s;
  logic        bit_slip_r;
  logic        locked_r;
  logic        good_s;

  assign good_s = is_good_byte(DATA_IN, prev_r);

  // Next-state and counter update for the alignment search.
  always_comb begin
    state_s     = state_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    wait_cnt_s  = wait_cnt_r;
    if (!TRAIN_EN) begin
      state_s     = ST_SEARCH;
      match_cnt_s = 8'd0;
      miss_cnt_s  = 4'd0;
      wait_cnt_s  = 8'd0;
    end else begin
      case (state_r)
        ST_SEARCH: begin
          if (DATA_VALID) begin
            if (good_s) begin
              if (match_cnt_r == MATCH_LAST) begin
                state_s     = ST_LOCK;
                match_cnt_s = 8'd0;
                miss_cnt_s  = 4'd0;
              end else begin
                match_cnt_s = match_cnt_r + 8'd1;
              end
            end else begin
              match_cnt_s = 8'd0;
              state_s     = ST_SLIP;
            end
          end else begin
            match_cnt_s = match_cnt_r;
          end
        end
        ST_SLIP: begin
          state_s    = ST_WAIT;
          wait_cnt_s = 8'd0;
        end
        // Deserializer needs time to settle after a slip; incoming data is ignored here.
        ST_WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_s     = ST_SEARCH;
            wait_cnt_s  = 8'd0;
            match_cnt_s = 8'd0;
          end else begin
            wait_cnt_s = wait_cnt_r + 8'd1;
          end
        end
        ST_LOCK: begin
          if (DATA_VALID) begin
            if (good_s) begin
              miss_cnt_s = 4'd0;
            end else if (miss_cnt_r == LOSS_LAST) begin
              state_s     = ST_SEARCH;
              miss_cnt_s  = 4'd0;
              match_cnt_s = 8'd0;
            end else begin
              miss_cnt_s = miss_cnt_r + 4'd1;
            end
          end else begin
            miss_cnt_s = miss_cnt_r;
          end
        end
        default: begin
          state_s     = ST_SEARCH;
          match_cnt_s = 8'd0;
          miss_cnt_s  = 4'd0;
          wait_cnt_s  = 8'd0;
        end
      endcase
    end
  end

  // State, counters, byte history and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_SEARCH;
      prev_r      <= 8'h00;
      match_cnt_r <= 8'd0;
      miss_cnt_r  <= 4'd0;
      wait_cnt_r  <= 8'd0;
      bit_slip_r  <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      wait_cnt_r  <= wait_cnt_s;
      bit_slip_r  <= (state_s == ST_SLIP);
      locked_r    <= (state_s == ST_LOCK);
      if (DATA_VALID) begin
        prev_r <= DATA_IN;
      end
    end
  end

  assign BIT_SLIP = bit_slip_r;
  assign LOCKED   = locked_r;

`ifdef RCB_FRL_TRAIN_ERRCNT_EN
  logic        train_en_d_r;
  logic [15:0] err_cnt_r;
  logic        bad_in_lock_s;

  assign bad_in_lock_s = TRAIN_EN && (state_r == ST_LOCK) && DATA_VALID && !good_s;

  // Saturating count of bad bytes in lock; a fresh training enable starts a new count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      train_en_d_r <= 1'b0;
      err_cnt_r    <= 16'h0000;
    end else begin
      train_en_d_r <= TRAIN_EN;
      if (TRAIN_EN && !train_en_d_r) begin
        err_cnt_r <= 16'h0000;
      end else if (bad_in_lock_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign ERR_CNT = err_cnt_r;
`else
  assign ERR_CNT = 16'h0000;
`endif

  rcb_frl_training_detect_chk u_chk (
    .CLK      (CLK),
    .RST      (RST),
    .TRAIN_EN (TRAIN_EN),
    .BIT_SLIP (BIT_SLIP),
    .LOCKED   (LOCKED)
  );

endmodule

// Output invariants of the detector: slip pulses isolated, disable takes effect next cycle.
module rcb_frl_training_detect_chk (
  input logic CLK,
  input logic RST,
  input logic TRAIN_EN,
  input logic BIT_SLIP,
  input logic LOCKED
);

  a_slip_isolated: assert property (@(posedge CLK) disable iff (RST) BIT_SLIP |=> !BIT_SLIP);
  a_disable_quiet: assert property (@(posedge CLK) disable iff (RST) !TRAIN_EN |=> (!BIT_SLIP && !LOCKED));
  a_slip_not_locked: assert property (@(posedge CLK) disable iff (RST) !(BIT_SLIP && LOCKED));

endmodule

// File: tb/tb_rcb_frl_training_detect.sv
// Self-checking bench for rcb_frl_training_detect: table vectors, scoreboard, corner sequences.
module tb_rcb_frl_training_detect;

  logic        CLK = 1'b0;
  logic        RST;
  logic        TRAIN_EN;
  logic [7:0]  DATA_IN;
  logic        DATA_VALID;
  logic        BIT_SLIP;
  logic        LOCKED;
  logic [15:0] ERR_CNT;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef RCB_FRL_TRAIN_ERRCNT_EN
  localparam logic ERRC = 1'b1;
`else
  localparam logic ERRC = 1'b0;
`endif

  typedef struct packed {
    logic slip;
    logic locked;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       es;
    logic       el;
  } vec_t;

  exp_t sbq[$];

  always #5 CLK = ~CLK;

  rcb_frl_training_detect dut (
    .CLK        (CLK),
    .RST        (RST),
    .TRAIN_EN   (TRAIN_EN),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .BIT_SLIP   (BIT_SLIP),
    .LOCKED     (LOCKED),
    .ERR_CNT    (ERR_CNT)
  );

  task automatic check(input string name, input string sig, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h expected %0h at %0t", name, sig, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expected outputs go through the scoreboard queue.
  task automatic cyc(input string name, input logic en, input logic v, input logic [7:0] d,
                     input logic es, input logic el);
    exp_t e;
    TRAIN_EN   = en;
    DATA_VALID = v;
    DATA_IN    = d;
    e.slip   = es;
    e.locked = el;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    check(name, "BIT_SLIP", {15'd0, BIT_SLIP}, {15'd0, e.slip});
    check(name, "LOCKED", {15'd0, LOCKED}, {15'd0, e.locked});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   nv;

    // Loss-of-lock vectors: three bad (with a valid gap) then good, then four bad.
    tbl[0] = '{en:1'b1, v:1'b1, d:8'h00, es:1'b0, el:1'b1};
    tbl[1] = '{en:1'b1, v:1'b1, d:8'h00, es:1'b0, el:1'b1};
    tbl[2] = '{en:1'b1, v:1'b0, d:8'h00, es:1'b0, el:1'b1};
    tbl[3] = '{en:1'b1, v:1'b1, d:8'h00, es:1'b0, el:1'b1};
    tbl[4] = '{en:1'b1, v:1'b1, d:8'hF4, es:1'b0, el:1'b1};
    tbl[5] = '{en:1'b1, v:1'b1, d:8'h00, es:1'b0, el:1'b1};
    tbl[6] = '{en:1'b1, v:1'b1, d:8'h00, es:1'b0, el:1'b1};
    tbl[7] = '{en:1'b1, v:1'b1, d:8'h00, es:1'b0, el:1'b1};
    tbl[8] = '{en:1'b1, v:1'b0, d:8'h00, es:1'b0, el:1'b1};
    tbl[9] = '{en:1'b1, v:1'b1, d:8'h00, es:1'b0, el:1'b0};

    RST        = 1'b1;
    TRAIN_EN   = 1'b0;
    DATA_VALID = 1'b0;
    DATA_IN    = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check("reset", "BIT_SLIP", {15'd0, BIT_SLIP}, 16'd0);
    check("reset", "LOCKED", {15'd0, LOCKED}, 16'd0);
    check("reset", "ERR_CNT", ERR_CNT, 16'd0);
    RST = 1'b0;

    // Clean aligned stream locks after exactly MATCH_LEN good bytes.
    for (int i = 0; i < 64; i++)
      cyc("lock0", 1'b1, 1'b1, (i % 2 == 0) ? 8'hF4 : 8'hC2, 1'b0, (i == 63));
    check("lock0", "ERR_CNT", ERR_CNT, 16'd0);

    for (int i = 0; i < 10; i++) begin
      cyc("loss_tbl", tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].es, tbl[i].el);
      if (i == 4) check("loss_tbl_3bad", "ERR_CNT", ERR_CNT, ERRC ? 16'd3 : 16'd0);
    end
    check("loss_tbl_end", "ERR_CNT", ERR_CNT, ERRC ? 16'd7 : 16'd0);

    // Misaligned stream: slip pulses every 1+SLIP_WAIT+1 cycles.
    for (int i = 0; i < 21; i++)
      cyc("misalign", 1'b1, 1'b1, (i % 2 == 0) ? 8'h7A : 8'h15, (i % 10 == 0), 1'b0);
    // 9 bytes swallowed by SLIP/WAIT, then 64 counted.
    for (int j = 0; j < 73; j++)
      cyc("realign", 1'b1, 1'b1, (j % 2 == 0) ? 8'hF4 : 8'hC2, 1'b0, (j == 72));

    check("pre_drop", "ERR_CNT", ERR_CNT, ERRC ? 16'd7 : 16'd0);
    cyc("en_drop_lock", 1'b0, 1'b1, 8'hC2, 1'b0, 1'b0);

    for (int j = 0; j < 30; j++)
      cyc("search30", 1'b1, 1'b1, (j % 2 == 0) ? 8'hF4 : 8'hC2, 1'b0, 1'b0);
    check("en_rise", "ERR_CNT", ERR_CNT, 16'd0);
    cyc("repeat_byte", 1'b1, 1'b1, 8'hC2, 1'b1, 1'b0);
    for (int j = 0; j < 73; j++)
      cyc("relock", 1'b1, 1'b1, (j % 2 == 0) ? 8'hF4 : 8'hC2, 1'b0, (j == 72));

    cyc("en_drop_lock2", 1'b0, 1'b1, 8'hC2, 1'b0, 1'b0);
    cyc("slip_enter", 1'b1, 1'b1, 8'hC2, 1'b1, 1'b0);
    cyc("en_drop_slip", 1'b0, 1'b1, 8'hF4, 1'b0, 1'b0);

    // Back in SEARCH immediately; 5-cycle valid gaps must not disturb the count.
    nv = 0;
    while (nv < 64) begin
      cyc("gap_lock", 1'b1, 1'b1, (nv % 2 == 0) ? 8'hC2 : 8'hF4, 1'b0, (nv == 63));
      nv++;
      if ((nv % 16 == 0) && (nv < 64))
        repeat (5) cyc("gap_idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Two repeated bytes in lock, then an asynchronous reset between edges.
    cyc("pre_rst_bad", 1'b1, 1'b1, 8'hF4, 1'b0, 1'b1);
    cyc("pre_rst_bad", 1'b1, 1'b1, 8'hF4, 1'b0, 1'b1);
    check("pre_rst", "ERR_CNT", ERR_CNT, ERRC ? 16'd2 : 16'd0);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst", "LOCKED", {15'd0, LOCKED}, 16'd0);
    check("async_rst", "ERR_CNT", ERR_CNT, 16'd0);
    check("async_rst", "BIT_SLIP", {15'd0, BIT_SLIP}, 16'd0);
    #1;
    RST = 1'b0;
    repeat (3) cyc("post_rst_idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("post_rst_first", 1'b1, 1'b1, 8'hF4, 1'b0, 1'b0);
    cyc("post_rst_rep", 1'b1, 1'b1, 8'hF4, 1'b1, 1'b0);
    cyc("post_rst_after", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
